shift_deser: RTL and testbench

//  Serial-to-parallel receiver; the receive end of the MSB-first shift-register serial path.

---
 rtl/shift_pkg.sv | 19 +
 rtl/word_hold.sv | 46 ++++
 rtl/shift_deser.sv | 101 ++++++++++
 tb/tb_shift_deser.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the MSB-first shift-register serial path (transmit and receive sides).
package shift_pkg;

  typedef enum logic {ST_IDLE, ST_SHIFT} shift_state_t;

  // Both ends of the link agree that the first bit on the wire is the word MSB.
  localparam int SHIFT_MSB_FIRST = 1;

  // Counter width for a WIDTH-bit word, never narrower than one bit.
  function automatic int clog2w(input int w);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/word_hold.sv
// One-entry valid/ready holding register; a load while full and not draining is dropped (drop pulses).
// Loaded word is visible the cycle after load; a same-cycle accept and load keeps valid high with new data.
module word_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             full,
  output logic             drop
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             accept;

  assign accept = vld_q & out_rdy;
  assign drop   = load & vld_q & ~out_rdy;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (accept) vld_d = 1'b0;
    if (load && !drop) begin
      vld_d = 1'b1;
      dat_d = load_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_dat = dat_q;
  assign full    = vld_q;

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: WIDTH bits MSB first into a word, word valid the cycle after its last bit.
// A one-word holding register absorbs consumer stalls; a word completing while it is still full is dropped and flagged.
module shift_deser #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_sof,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic             busy
);
  import shift_pkg::*;

  localparam int CNT_W = clog2w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  shift_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] shift_word;
  logic             load;
  logic             drop;

  assign shift_word = {shreg_q[WIDTH-2:0], sin};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sin_valid && sin_sof) begin
          state_d = ST_SHIFT;
          shreg_d = {{(WIDTH-1){1'b0}}, sin};
          cnt_d   = CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (sin_valid) begin
          if (sin_sof && cnt_q != '0) begin
            // Resync: the partial word is abandoned, this bit starts a new one.
            shreg_d = {{(WIDTH-1){1'b0}}, sin};
            cnt_d   = CNT_W'(1);
          end else begin
            shreg_d = shift_word;
            if (cnt_q == LAST_BIT) begin
              cnt_d = '0;
              load  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (overflow_clr) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ovf_q   <= ovf_d;
    end
  end

  word_hold #(.WIDTH(WIDTH)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_dat (shift_word),
    .out_rdy  (data_ready),
    .out_dat  (data_out),
    .full     (data_valid),
    .drop     (drop)
  );

  assign overflow = ovf_q;
  assign busy     = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_shift_deser.sv
// Directed and randomized bench for shift_deser (WIDTH=8) against a bit-counting reference model.
module tb_shift_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sin = 1'b0, sin_valid = 1'b0, sin_sof = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b0;
  logic       overflow;
  logic       overflow_clr = 1'b0;
  logic       busy;

  shift_deser #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sin          (sin),
    .sin_valid    (sin_valid),
    .sin_sof      (sin_sof),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_cyc  = 0;
  int last_bit = 0;
  logic rdy = 1'b0;
  logic clr = 1'b0;
  logic [7:0] got[$];
  int vcyc[$];

  // Reference model: frame flag, bit count within the word, numeric accumulator, holding slot.
  bit         m_frame;
  int         m_n;
  int         m_acc;
  bit         m_vld;
  logic [7:0] m_dat;
  bit         m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_frame = 0; m_n = 0; m_acc = 0; m_vld = 0; m_dat = 8'h00; m_ovf = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(data_valid), 32'(m_vld));
    check({tag, ".data"},  32'(data_out),   32'(m_dat));
    check({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
    check({tag, ".busy"},  32'(busy),       32'(m_frame));
  endtask

  // One clock: drive inputs, advance the model, sample after the edge.
  task automatic cyc(input logic s, input logic v, input logic f);
    bit take, done, drop;
    sin = s; sin_valid = v; sin_sof = f; data_ready = rdy; overflow_clr = clr;
    if (data_valid && data_ready) got.push_back(data_out);
    take = m_vld && rdy; done = 0; drop = 0;
    if (v) begin
      if (f && (!m_frame || m_n != 0)) begin
        m_frame = 1; m_acc = int'(s); m_n = 1;
      end else if (m_frame) begin
        m_acc = (m_acc * 2 + int'(s)) % 256;
        m_n++;
        if (m_n == 8) begin done = 1; m_n = 0; end
      end
    end
    if (done) begin
      if (m_vld && !rdy) drop = 1;
      else begin m_vld = 1; m_dat = 8'(m_acc); end
    end else if (take) begin
      m_vld = 0;
    end
    if (clr) m_ovf = 0;
    if (drop) m_ovf = 1;
    @(posedge clk); #1;
    n_cyc++;
    if (data_valid) vcyc.push_back(n_cyc);
    check_outputs("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_word(input logic [7:0] w, input bit sof_first, input int bubble_pct);
    for (int i = 7; i >= 0; i--) begin
      while (int'($urandom_range(0, 99)) < bubble_pct) cyc(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      cyc(w[i], 1'b1, 1'(sof_first && i == 7));
    end
    last_bit = n_cyc;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic mid_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check({tag, ".rst_valid"}, 32'(data_valid), 32'd0);
    check({tag, ".rst_data"},  32'(data_out),   32'd0);
    check({tag, ".rst_ovf"},   32'(overflow),   32'd0);
    check({tag, ".rst_busy"},  32'(busy),       32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    model_reset();
    #2;
    mid_reset("t1");
    @(posedge clk); #1;
    idle(3);

    // Single word, consumer always ready.
    rdy = 1; got.delete(); vcyc.delete();
    send_word(8'hA5, 1, 0);
    idle(3);
    check("t2.words", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("t2.word0", 32'(got[0]), 32'hA5);
    check("t2.pulses", 32'(vcyc.size()), 32'd1);
    if (vcyc.size() > 0) check("t2.latency", 32'(vcyc[0]), 32'(last_bit));

    // Contiguous words, sof only on the first.
    got.delete(); vcyc.delete();
    send_word(8'hA5, 1, 0);
    send_word(8'h3C, 0, 0);
    idle(3);
    check("t3.words", 32'(got.size()), 32'd2);
    if (got.size() > 1) begin
      check("t3.word0", 32'(got[0]), 32'hA5);
      check("t3.word1", 32'(got[1]), 32'h3C);
    end
    check("t3.pulses", 32'(vcyc.size()), 32'd2);
    if (vcyc.size() > 1) check("t3.spacing", 32'(vcyc[1] - vcyc[0]), 32'd8);
    check("t3.ovf", 32'(overflow), 32'd0);

    // Stalled consumer: second word dropped, overflow sticky until cleared.
    mid_reset("t4pre");
    rdy = 0; got.delete();
    send_word(8'hA5, 1, 0);
    send_word(8'h3C, 0, 0);
    check("t4.hold", 32'(data_out), 32'hA5);
    check("t4.ovf_set", 32'(overflow), 32'd1);
    idle(2);
    rdy = 1;
    idle(1);
    check("t4.valid_drop", 32'(data_valid), 32'd0);
    check("t4.ovf_sticky", 32'(overflow), 32'd1);
    clr = 1;
    idle(1);
    clr = 0;
    check("t4.ovf_clr", 32'(overflow), 32'd0);
    check("t4.words", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("t4.word0", 32'(got[0]), 32'hA5);

    // Resync: partial word abandoned by a new sof.
    mid_reset("t5pre");
    rdy = 1; got.delete();
    cyc(1, 1, 1); cyc(1, 1, 0); cyc(0, 1, 0);
    send_word(8'h3C, 1, 0);
    idle(3);
    check("t5.words", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("t5.word0", 32'(got[0]), 32'h3C);
    check("t5.ovf", 32'(overflow), 32'd0);

    // Reset mid-word, then a clean frame, then a bubbled frame.
    got.delete();
    cyc(0, 1, 1); cyc(1, 1, 0); cyc(0, 1, 0); cyc(1, 1, 0);
    mid_reset("t6");
    idle(2);
    check("t6.no_valid", 32'(got.size()), 32'd0);
    send_word(8'h5A, 1, 0);
    send_word(8'hA5, 0, 40);
    idle(3);
    check("t6.words", 32'(got.size()), 32'd2);
    if (got.size() > 1) begin
      check("t6.word0", 32'(got[0]), 32'h5A);
      check("t6.word1", 32'(got[1]), 32'hA5);
    end

    // Randomized traffic: stalls, bubbles, stray sof, overflow clears.
    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(0, 99) < 60);
      clr = ($urandom_range(0, 99) < 4);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 80), 1'($urandom_range(0, 99) < 6));
    end
    clr = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
